lsp_shared_unit_arbiter: RTL and testbench
==========================================

// Module: lsp_shared_unit_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one scratch-memory port and one add/sub/L_add unit set
//  among NREQ sub-FSMs (prev-update, expand, copy-style routines) inside the LSP quantizer.
//  Grants one requester at a time, pulses that client's start, routes its datapath/memory buses
//  to the shared units until the client's done, then releases. Result buses (memIn, addIn,
//  subIn, L_addIn) are wired to all clients outside this block.
// PARAMETERS
//  NREQ     4    number of requesters (2..8)
//  PTR_W    2    width of grant index, clog2(NREQ)
//  TIMEOUT  1024 max RUN cycles before forced release; 0 disables watchdog
// PORTS
//  clk           in   1         clock
//  reset         in   1         synchronous, active-high
//  req           in   NREQ      level request per client; held until ack
//  client_start  out  NREQ      one-cycle start pulse to granted client
//  client_done   in   NREQ      client done pulse
//  ack           out  NREQ      one-cycle completion pulse back to requester
//  grant         out  NREQ      one-hot current owner, 0 when idle
//  busy          out  1         1 in START/RUN/RELEASE
//  err           out  1         one-cycle pulse on watchdog release
//  err_id        out  PTR_W     index of client that timed out (held until next err)
//  c_addA/c_addB in   16*NREQ   client add operands, client i at [16i+15:16i]
//  c_subA/c_subB in   16*NREQ   client sub operands
//  c_LaddA/c_LaddB in 32*NREQ   client L_add operands
//  c_rdAddr/c_wrAddr in 11*NREQ client memory read/write addresses
//  c_memOut      in   32*NREQ   client write data
//  c_memWe       in   NREQ      client write enable
//  addOutA/B, subOutA/B  out 16; L_addOutA/B out 32; memReadAddr/memWriteAddr out 11;
//  memOut out 32; memWriteEn out 1   -- shared-unit buses
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, ptr=0, cnt=0, err=0, err_id=0, ack=0, client_start=0; all shared
//   buses 0, memWriteEn=0. Reset mid-operation aborts immediately; no ack issued.
//  Registered: state, grant index g, ptr (round-robin base), cnt, ack, err, err_id.
//  IDLE: if |req, select first set bit searching ptr, ptr+1, .. wrapping mod NREQ; g<=winner;
//   ->START. Arbitration decision made in one cycle; no req -> stay.
//  START (1 cycle): client_start[g]=1, buses routed from client g. ->RUN.
//  RUN: buses routed from client g; cnt increments. client_done[g]=1 -> RELEASE with ack pending.
//   cnt==TIMEOUT-1 (TIMEOUT!=0) without done -> RELEASE, err pending, err_id<=g.
//   Done at same cycle as timeout: done wins, no err.
//  RELEASE (1 cycle): ack[g]=1 (or err=1); buses all 0, memWriteEn=0; ptr<=g+1 mod NREQ;
//   cnt<=0; ->IDLE. Grant gap between owners is therefore 2 cycles (RELEASE, IDLE).
//  Routing: combinational mux on registered g while in START/RUN; otherwise all shared outputs 0.
//   Non-owner client buses, c_memWe and client_done are ignored (never reach shared units).
//  grant one-hot of g in START/RUN/RELEASE, 0 in IDLE. Latency req->client_start: 1 cycle
//   when idle. client_done->ack: 1 cycle.
//  req deasserted while granted: no effect; client runs to done. req not re-sampled until IDLE.
//  Width rules: pure routing, no arithmetic on data; ptr/cnt wrap modulo their ranges.
// TESTING
//  1 req=0001 from idle -> client_start[0] next cycle; done after 20 cycles -> ack=0001 1 cycle later.
//  2 req=0101 same cycle, ptr=0 -> client 0 served, then client 2; ptr=3 after second RELEASE.
//  3 req[1] held continuously with req[3] -> grants alternate 1,3,1,3 (no starvation).
//  4 c_memWe[2]=1, client_done[2]=1 while g=0 -> memWriteEn tracks client 0 only, no ack[2].
//  5 TIMEOUT=8, client never done -> err pulse after 8 RUN cycles, err_id=g, no ack, next served.
//  6 reset in RUN with memWriteEn=1 -> next cycle memWriteEn=0, grant=0, state IDLE, no ack.

Source files
------------

// File: rtl/lsp_shared_unit_arbiter.sv
// Round-robin owner of the LSP quantizer's shared scratch-memory port and
// add/sub/L_add units. One sub-FSM at a time is granted, started, and has its
// operand/memory buses routed to the shared units until it reports done.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   S_IDLE    | no owner; round-robin search of req starting at ptr
//   S_START   | one-cycle start pulse to owner g; owner buses already routed
//   S_RUN     | owner g drives shared units; cnt tracks run length
//   S_RELEASE | ack (or watchdog err) pulse; shared buses parked at 0
module lsp_shared_unit_arbiter #(
    parameter int NREQ    = 4,
    parameter int PTR_W   = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    output logic [NREQ-1:0]      client_start,
    input  logic [NREQ-1:0]      client_done,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic                 err,
    output logic [PTR_W-1:0]     err_id,
    input  logic [16*NREQ-1:0]   c_addA,
    input  logic [16*NREQ-1:0]   c_addB,
    input  logic [16*NREQ-1:0]   c_subA,
    input  logic [16*NREQ-1:0]   c_subB,
    input  logic [32*NREQ-1:0]   c_LaddA,
    input  logic [32*NREQ-1:0]   c_LaddB,
    input  logic [11*NREQ-1:0]   c_rdAddr,
    input  logic [11*NREQ-1:0]   c_wrAddr,
    input  logic [32*NREQ-1:0]   c_memOut,
    input  logic [NREQ-1:0]      c_memWe,
    output logic [15:0]          addOutA,
    output logic [15:0]          addOutB,
    output logic [15:0]          subOutA,
    output logic [15:0]          subOutB,
    output logic [31:0]          L_addOutA,
    output logic [31:0]          L_addOutB,
    output logic [10:0]          memReadAddr,
    output logic [10:0]          memWriteAddr,
    output logic [31:0]          memOut,
    output logic                 memWriteEn
);

    // cnt only needs to reach TIMEOUT-1; with the watchdog disabled it just wraps
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_RUN     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PTR_W-1:0] g;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] g_inc;
    logic [CNT_W-1:0] cnt;
    logic             found;
    logic [NREQ-1:0]  g_onehot;
    logic             owner_done;
    logic             timeout_hit;
    logic             route;
    int               gi;

    // Round-robin search: first set request at ptr, ptr+1, ... modulo NREQ
    always_comb begin : arb_search
        int idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

    // Owner decode, done/timeout qualification and pointer advance
    always_comb begin
        g_onehot    = '0;
        g_onehot[g] = 1'b1;
        gi          = int'(g);
        g_inc       = (g == PTR_W'(NREQ - 1)) ? '0 : g + PTR_W'(1);
        owner_done  = client_done[g];
        timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
    end

    // Next-state logic; done takes priority over a coincident timeout
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (found) state_nxt = S_START;
            S_START:   state_nxt = S_RUN;
            S_RUN:     if (owner_done || timeout_hit) state_nxt = S_RELEASE;
            S_RELEASE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // State, owner, pointer, run counter and completion pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            g      <= '0;
            ptr    <= '0;
            cnt    <= '0;
            ack    <= '0;
            err    <= 1'b0;
            err_id <= '0;
        end else begin
            state <= state_nxt;
            ack   <= '0;
            err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) g <= winner;
                end
                S_RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (owner_done) begin
                        ack <= g_onehot;
                    end else if (timeout_hit) begin
                        err    <= 1'b1;
                        err_id <= g;
                    end
                end
                S_RELEASE: begin
                    ptr <= g_inc;
                    cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // Status outputs and shared-bus routing from the owner only
    always_comb begin
        route        = (state == S_START) || (state == S_RUN);
        busy         = (state != S_IDLE);
        grant        = busy ? g_onehot : '0;
        client_start = (state == S_START) ? g_onehot : '0;
        addOutA      = '0;
        addOutB      = '0;
        subOutA      = '0;
        subOutB      = '0;
        L_addOutA    = '0;
        L_addOutB    = '0;
        memReadAddr  = '0;
        memWriteAddr = '0;
        memOut       = '0;
        memWriteEn   = 1'b0;
        if (route) begin
            addOutA      = c_addA[16*gi +: 16];
            addOutB      = c_addB[16*gi +: 16];
            subOutA      = c_subA[16*gi +: 16];
            subOutB      = c_subB[16*gi +: 16];
            L_addOutA    = c_LaddA[32*gi +: 32];
            L_addOutB    = c_LaddB[32*gi +: 32];
            memReadAddr  = c_rdAddr[11*gi +: 11];
            memWriteAddr = c_wrAddr[11*gi +: 11];
            memOut       = c_memOut[32*gi +: 32];
            memWriteEn   = c_memWe[g];
        end
    end

endmodule

// File: tb/tb_lsp_shared_unit_arbiter.sv
// Directed bench for lsp_shared_unit_arbiter. Two instances share all inputs:
// dut uses the default watchdog, dut_wd uses TIMEOUT=8 for the watchdog steps.
module tb_lsp_shared_unit_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic [3:0]   req, client_done, c_memWe;
    logic [63:0]  c_addA, c_addB, c_subA, c_subB;
    logic [127:0] c_LaddA, c_LaddB, c_memOut;
    logic [43:0]  c_rdAddr, c_wrAddr;

    logic [3:0]  client_start, ack, grant;
    logic        busy, err, memWriteEn;
    logic [1:0]  err_id;
    logic [15:0] addOutA, addOutB, subOutA, subOutB;
    logic [31:0] L_addOutA, L_addOutB, memOut;
    logic [10:0] memReadAddr, memWriteAddr;

    logic [3:0]  w_client_start, w_ack, w_grant;
    logic        w_busy, w_err, w_memWriteEn;
    logic [1:0]  w_err_id;
    logic [15:0] w_addOutA, w_addOutB, w_subOutA, w_subOutB;
    logic [31:0] w_L_addOutA, w_L_addOutB, w_memOut;
    logic [10:0] w_memReadAddr, w_memWriteAddr;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lsp_shared_unit_arbiter #(.NREQ(4), .PTR_W(2), .TIMEOUT(1024)) dut (
        .clk(clk), .reset(reset), .req(req), .client_start(client_start),
        .client_done(client_done), .ack(ack), .grant(grant), .busy(busy),
        .err(err), .err_id(err_id), .c_addA(c_addA), .c_addB(c_addB),
        .c_subA(c_subA), .c_subB(c_subB), .c_LaddA(c_LaddA), .c_LaddB(c_LaddB),
        .c_rdAddr(c_rdAddr), .c_wrAddr(c_wrAddr), .c_memOut(c_memOut),
        .c_memWe(c_memWe), .addOutA(addOutA), .addOutB(addOutB),
        .subOutA(subOutA), .subOutB(subOutB), .L_addOutA(L_addOutA),
        .L_addOutB(L_addOutB), .memReadAddr(memReadAddr),
        .memWriteAddr(memWriteAddr), .memOut(memOut), .memWriteEn(memWriteEn)
    );

    lsp_shared_unit_arbiter #(.NREQ(4), .PTR_W(2), .TIMEOUT(8)) dut_wd (
        .clk(clk), .reset(reset), .req(req), .client_start(w_client_start),
        .client_done(client_done), .ack(w_ack), .grant(w_grant), .busy(w_busy),
        .err(w_err), .err_id(w_err_id), .c_addA(c_addA), .c_addB(c_addB),
        .c_subA(c_subA), .c_subB(c_subB), .c_LaddA(c_LaddA), .c_LaddB(c_LaddB),
        .c_rdAddr(c_rdAddr), .c_wrAddr(c_wrAddr), .c_memOut(c_memOut),
        .c_memWe(c_memWe), .addOutA(w_addOutA), .addOutB(w_addOutB),
        .subOutA(w_subOutA), .subOutB(w_subOutB), .L_addOutA(w_L_addOutA),
        .L_addOutB(w_L_addOutB), .memReadAddr(w_memReadAddr),
        .memWriteAddr(w_memWriteAddr), .memOut(w_memOut), .memWriteEn(w_memWriteEn)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        req         = '0;
        client_done = '0;
        c_memWe     = '0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    // Entered in IDLE with req already set; idx must be the expected winner.
    task automatic serve(input int idx, input int run_cycles, input bit drop);
        logic [3:0] exp;
        exp = 4'b0001 << idx;
        cyc();
        check("start_grant", 32'(grant), 32'(exp));
        check("start_pulse", 32'(client_start), 32'(exp));
        check("start_addA", 32'(addOutA), 32'(16'hA0A0 + 16'(idx)));
        check("start_LaddB", 32'(L_addOutB), 32'h2222_0000 + 32'(idx));
        check("start_rdAddr", 32'(memReadAddr), 32'(11'h100 + 11'(idx)));
        cyc();
        check("run_pulse_clear", 32'(client_start), 32'h0);
        check("run_grant", 32'(grant), 32'(exp));
        repeat (run_cycles - 1) cyc();
        client_done = exp;
        cyc();
        client_done = '0;
        check("rel_ack", 32'(ack), 32'(exp));
        check("rel_grant", 32'(grant), 32'(exp));
        check("rel_memOut_zero", memOut, 32'h0);
        check("rel_addA_zero", 32'(addOutA), 32'h0);
        if (drop) req = req & ~exp;
        cyc();
        check("idle_ack", 32'(ack), 32'h0);
        check("idle_grant", 32'(grant), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            c_addA[16*i +: 16]   = 16'hA0A0 + 16'(i);
            c_addB[16*i +: 16]   = 16'hB0B0 + 16'(i);
            c_subA[16*i +: 16]   = 16'hC0C0 + 16'(i);
            c_subB[16*i +: 16]   = 16'hD0D0 + 16'(i);
            c_LaddA[32*i +: 32]  = 32'h1111_0000 + 32'(i);
            c_LaddB[32*i +: 32]  = 32'h2222_0000 + 32'(i);
            c_rdAddr[11*i +: 11] = 11'h100 + 11'(i);
            c_wrAddr[11*i +: 11] = 11'h200 + 11'(i);
            c_memOut[32*i +: 32] = 32'hDEAD_0000 + 32'(i);
        end

        // Reset state
        do_reset();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_start", 32'(client_start), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_err_id", 32'(err_id), 32'h0);
        check("rst_memWe", 32'(memWriteEn), 32'h0);
        check("rst_addA", 32'(addOutA), 32'h0);

        // Single client, done after 20 run cycles
        req = 4'b0001;
        serve(0, 20, 1'b1);

        // Two simultaneous requests from ptr=0: 0 then 2; ptr ends at 3
        do_reset();
        req = 4'b0101;
        serve(0, 1, 1'b1);
        serve(2, 1, 1'b1);
        req = 4'b1001;
        serve(3, 1, 1'b1);
        serve(0, 1, 1'b1);

        // Two continuous requesters alternate
        do_reset();
        req = 4'b1010;
        serve(1, 3, 1'b0);
        serve(3, 3, 1'b0);
        serve(1, 3, 1'b0);
        serve(3, 3, 1'b0);
        req = '0;
        cyc();
        check("rr_idle_grant", 32'(grant), 32'h0);

        // Non-owner write enable and done never reach the shared side
        do_reset();
        req = 4'b0001;
        cyc();
        req     = '0;
        c_memWe = 4'b0100;
        #1;
        check("iso_we_nonowner", 32'(memWriteEn), 32'h0);
        c_memWe = 4'b0101;
        #1;
        check("iso_we_owner", 32'(memWriteEn), 32'h1);
        client_done = 4'b0100;
        cyc();
        check("iso_no_ack", 32'(ack), 32'h0);
        check("iso_still_run", 32'(grant), 32'h1);
        check("iso_wrAddr", 32'(memWriteAddr), 32'h200);
        client_done = 4'b0001;
        cyc();
        client_done = '0;
        check("iso_ack0", 32'(ack), 32'h1);
        check("iso_rel_we", 32'(memWriteEn), 32'h0);
        c_memWe = '0;
        cyc();

        // Watchdog (TIMEOUT=8): done on the last run cycle wins, then a timeout
        do_reset();
        req = 4'b0011;
        cyc();
        check("wd_start0", 32'(w_grant), 32'h1);
        cyc();
        repeat (7) cyc();
        client_done = 4'b0001;
        cyc();
        client_done = '0;
        check("wd_edge_ack", 32'(w_ack), 32'h1);
        check("wd_edge_no_err", 32'(w_err), 32'h0);
        req = 4'b0010;
        cyc();
        cyc();
        check("wd_start1", 32'(w_client_start), 32'h2);
        cyc();
        repeat (7) cyc();
        check("wd_pre_err", 32'(w_err), 32'h0);
        check("wd_pre_busy", 32'(w_grant), 32'h2);
        cyc();
        check("wd_err", 32'(w_err), 32'h1);
        check("wd_err_id", 32'(w_err_id), 32'h1);
        check("wd_no_ack", 32'(w_ack), 32'h0);
        req = 4'b0011;
        cyc();
        check("wd_err_pulse", 32'(w_err), 32'h0);
        check("wd_err_id_hold", 32'(w_err_id), 32'h1);
        cyc();
        check("wd_next_served", 32'(w_grant), 32'h1);

        // Reset during RUN aborts at once
        do_reset();
        req = 4'b0001;
        cyc();
        c_memWe = 4'b0001;
        cyc();
        check("abort_pre_we", 32'(memWriteEn), 32'h1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        req   = '0;
        check("abort_we", 32'(memWriteEn), 32'h0);
        check("abort_grant", 32'(grant), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_ack", 32'(ack), 32'h0);
        cyc();
        check("abort_no_late_ack", 32'(ack), 32'h0);
        check("abort_idle", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
